// File: rtl/gpu_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package gpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int          INST_BYTES        = 4;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready payload register with explicit load and flush; flush wins over load.
// Latency 1 cycle; payload holds while valid && !rdy_i, clears valid on accept without load.
module fetch_out_reg #(
    parameter int DAT_BITS = 40
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                flush_i,
    input  logic [DAT_BITS-1:0] dat_i,
    output logic                vld_o,
    input  logic                rdy_i,
    output logic [DAT_BITS-1:0] dat_o
);

    logic                r_vld;
    logic [DAT_BITS-1:0] r_dat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (flush_i) begin
            r_vld <= 1'b0;
        end else if (load_i) begin
            r_vld <= 1'b1;
            r_dat <= dat_i;
        end else if (rdy_i) begin
            r_vld <= 1'b0;
        end
    end

    assign vld_o = r_vld;
    assign dat_o = r_dat;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC + IDLE/RUN/HALT control feeding an IF/ID valid/ready register.
// Latency 1 cycle fetch-to-valid; stalls hold PC and payload. FETCH_PERF_CNT_EN adds perf counters.
module instruction_fetch
    import gpu_fetch_pkg::*;
#(
    parameter int                    WORD_BITS = 32,
    parameter int                    ADDR_BITS = 8,
    parameter logic [ADDR_BITS-1:0]  RESET_PC  = '0,
    parameter logic [WORD_BITS-1:0]  HALT_WORD = WORD_BITS'(HALT_WORD_DEFAULT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic [ADDR_BITS-1:0] imem_addr_o,
    input  logic [WORD_BITS-1:0] imem_rd_data_i,
    input  logic                 redirect_i,
    input  logic [ADDR_BITS-1:0] redirect_pc_i,
    output logic                 inst_valid_o,
    input  logic                 inst_ready_i,
    output logic [WORD_BITS-1:0] inst_o,
    output logic [ADDR_BITS-1:0] inst_pc_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]          fetch_count_o,
    output logic [31:0]          stall_count_o,
`endif
    output logic                 halted_o
);

    fetch_state_e                   r_state;
    logic [ADDR_BITS-1:0]           r_pc;
    logic                           w_vld;
    logic                           w_load;
    logic                           w_is_halt;
    logic [WORD_BITS+ADDR_BITS-1:0] w_out_dat;

    // Redirect steals the cycle, so a load never coincides with a flush.
    assign w_load    = (r_state == RUN) && (!w_vld || inst_ready_i) && !redirect_i;
    assign w_is_halt = (imem_rd_data_i == HALT_WORD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else if (redirect_i) begin
            r_pc <= redirect_pc_i & ~ADDR_BITS'(INST_BYTES - 1);
            if (r_state == HALT || (r_state == IDLE && start_i))
                r_state <= RUN;
        end else if (r_state == IDLE) begin
            if (start_i)
                r_state <= RUN;
        end else if (w_load) begin
            // The PC parks on the halt word so a later redirect is the only way out.
            if (w_is_halt)
                r_state <= HALT;
            else
                r_pc <= r_pc + ADDR_BITS'(INST_BYTES);
        end
    end

    fetch_out_reg #(
        .DAT_BITS (WORD_BITS + ADDR_BITS)
    ) u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_load),
        .flush_i (redirect_i),
        .dat_i   ({imem_rd_data_i, r_pc}),
        .vld_o   (w_vld),
        .rdy_i   (inst_ready_i),
        .dat_o   (w_out_dat)
    );

    assign imem_addr_o  = r_pc;
    assign inst_valid_o = w_vld;
    assign inst_o       = w_out_dat[WORD_BITS+ADDR_BITS-1:ADDR_BITS];
    assign inst_pc_o    = w_out_dat[ADDR_BITS-1:0];
    assign halted_o     = (r_state == HALT) && !w_vld;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_vld && inst_ready_i && r_fetch_cnt != '1)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_vld && !inst_ready_i && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fetch_count_o = r_fetch_cnt;
    assign stall_count_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a word-indexed combinational memory and a behavioural model.
module tb_instruction_fetch;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_rd_data_i;
    logic        redirect_i;
    logic [7:0]  redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [7:0]  inst_pc_o;
    logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_o;
    logic [31:0] stall_count_o;
`endif

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    assign imem_rd_data_i = mem[imem_addr_o[7:2]];

    instruction_fetch dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .imem_addr_o    (imem_addr_o),
        .imem_rd_data_i (imem_rd_data_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count_o  (fetch_count_o),
        .stall_count_o  (stall_count_o),
`endif
        .halted_o       (halted_o)
    );

    // Behavioural model: mode 0 idle, 1 running, 2 halted.
    int          m_mode;
    int          m_pc;
    bit          m_vld;
    logic [31:0] m_inst;
    int          m_ipc;
    longint      m_fetch;
    longint      m_stall;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_mode = 0; m_pc = 0; m_vld = 0; m_inst = 0; m_ipc = 0;
            m_fetch = 0; m_stall = 0;
        end else begin
            if (m_vld && inst_ready_i && m_fetch < 64'hFFFF_FFFF) m_fetch++;
            if (m_vld && !inst_ready_i && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (redirect_i) begin
                m_pc  = int'(redirect_pc_i) / 4 * 4;
                m_vld = 0;
                if (m_mode == 2 || (m_mode == 0 && start_i)) m_mode = 1;
            end else if (m_mode == 0) begin
                if (start_i) m_mode = 1;
            end else if (m_mode == 1 && (!m_vld || inst_ready_i)) begin
                m_inst = mem[m_pc / 4];
                m_ipc  = m_pc;
                m_vld  = 1;
                if (m_inst == HALT_W) m_mode = 2;
                else                  m_pc = (m_pc + 4) % 256;
            end else if (inst_ready_i) begin
                m_vld = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        chk("m_valid", {31'd0, inst_valid_o}, {31'd0, m_vld});
        chk("m_inst", inst_o, m_inst);
        chk("m_ipc", {24'd0, inst_pc_o}, 32'(m_ipc));
        chk("m_addr", {24'd0, imem_addr_o}, 32'(m_pc));
        chk("m_halted", {31'd0, halted_o}, {31'd0, (m_mode == 2 && !m_vld)});
`ifdef FETCH_PERF_CNT_EN
        chk("m_fetch_cnt", fetch_count_o, m_fetch[31:0]);
        chk("m_stall_cnt", stall_count_o, m_stall[31:0]);
`endif
    end

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1; start_i = 0; redirect_i = 0; redirect_pc_i = 0; inst_ready_i = 1;
        step(); step();
        rst_i = 0;
    endtask

    task automatic lit(input string name, input logic [31:0] inst, input logic [7:0] ipc,
                       input logic vld, input logic [7:0] addr);
        chk({name, "_valid"}, {31'd0, inst_valid_o}, {31'd0, vld});
        if (vld) begin
            chk({name, "_inst"}, inst_o, inst);
            chk({name, "_pc"}, {24'd0, inst_pc_o}, {24'd0, ipc});
        end
        chk({name, "_addr"}, {24'd0, imem_addr_o}, {24'd0, addr});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);

        // Reset state
        do_reset();
        lit("rst", 32'h0, 8'h00, 1'b0, 8'h00);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        step();

        // 1: streaming A..D, no gaps
        start_i = 1; step(); start_i = 0;
        lit("t1_run", 32'h0, 8'h00, 1'b0, 8'h00);
        step(); lit("t1_a", 32'hA000_0000, 8'h00, 1'b1, 8'h04);
        step(); lit("t1_b", 32'hA000_0001, 8'h04, 1'b1, 8'h08);
        step(); lit("t1_c", 32'hA000_0002, 8'h08, 1'b1, 8'h0C);
        step(); lit("t1_d", 32'hA000_0003, 8'h0C, 1'b1, 8'h10);

        // 2: stall on B
        do_reset(); step();
        start_i = 1; step(); start_i = 0;
        step(); step();
        lit("t2_b0", 32'hA000_0001, 8'h04, 1'b1, 8'h08);
        inst_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            step(); lit("t2_hold", 32'hA000_0001, 8'h04, 1'b1, 8'h08);
        end
        inst_ready_i = 1;
        step(); lit("t2_c", 32'hA000_0002, 8'h08, 1'b1, 8'h0C);

        // 3: redirect while stalled
        inst_ready_i = 0; step();
        redirect_i = 1; redirect_pc_i = 8'h22; step();
        redirect_i = 0;
        lit("t3_flush", 32'h0, 8'h00, 1'b0, 8'h20);
        step(); lit("t3_tgt", 32'hA000_0008, 8'h20, 1'b1, 8'h24);
        inst_ready_i = 1;

        // 4: halt sentinel then restart
        mem[2] = HALT_W;
        do_reset(); step();
        start_i = 1; step(); start_i = 0;
        step(); step();
        step(); lit("t4_halt", HALT_W, 8'h08, 1'b1, 8'h08);
        chk("t4_not_halted_yet", {31'd0, halted_o}, 32'd0);
        step(); lit("t4_drain", 32'h0, 8'h00, 1'b0, 8'h08);
        chk("t4_halted", {31'd0, halted_o}, 32'd1);
        step(); chk("t4_still_halted", {31'd0, halted_o}, 32'd1);
        chk("t4_addr_hold", {24'd0, imem_addr_o}, 32'h08);
        redirect_i = 1; redirect_pc_i = 8'h00; step(); redirect_i = 0;
        chk("t4_resumed", {31'd0, halted_o}, 32'd0);
        step(); lit("t4_refetch", 32'hA000_0000, 8'h00, 1'b1, 8'h04);
        mem[2] = 32'hA000_0002;

        // 5: PC wrap
        redirect_i = 1; redirect_pc_i = 8'hFC; step(); redirect_i = 0;
        lit("t5_redir", 32'h0, 8'h00, 1'b0, 8'hFC);
        step(); lit("t5_fc", 32'hA000_003F, 8'hFC, 1'b1, 8'h00);
        step(); lit("t5_wrap", 32'hA000_0000, 8'h00, 1'b1, 8'h04);

        // 6: reset mid-stream overrides start
        step();
`ifdef FETCH_PERF_CNT_EN
        chk("t6_cnt_pre", fetch_count_o, m_fetch[31:0]);
`endif
        rst_i = 1; start_i = 1; step(); rst_i = 0; start_i = 0;
        lit("t6_rst", 32'h0, 8'h00, 1'b0, 8'h00);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_cnt_zero", fetch_count_o, 32'h0);
`endif
        step(); lit("t6_idle", 32'h0, 8'h00, 1'b0, 8'h00);
        step(); lit("t6_idle2", 32'h0, 8'h00, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
